dbus_sram_responder: RTL and testbench

- Responder end of the data-bus load/store protocol that the memory stage initiates for OP_L/OP_S (LD/SD).
- Models a synthesizable, word-addressed 64-bit scratch-pad with a fixed, configurable response latency.
- Used as the data memory behind the pipeline in standalone core tests.

---
 rtl/dbus_sram_responder.sv | 138 +++++++++++++
 tb/tb_dbus_sram_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: a word-addressed 64-bit scratch-pad that answers one load or
// store at a time, LATENCY cycles after accepting it, with one idle bubble between requests.
module dbus_sram_responder #(
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [63:0] resp_data
);

   localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
   localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      addr_q, addr_d;
   logic [7:0]       strobe_q, strobe_d;
   logic [63:0]      data_q, data_d;

   logic [63:0]      mem [DEPTH_WORDS];
   logic [63:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             wr_en;

   // A latched address below BASE_ADDR wraps to a huge offset; the explicit compare
   // rejects it even when the wrapped offset happens to look small.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = (addr_q >= BASE_ADDR) && (offset[63:IDX_W+3] == '0);
   assign idx      = offset[IDX_W+2:3];

   // req_size and the byte offset inside a word never affect addressing.
   logic unused_ok;
   assign unused_ok = ^{req_size, req_addr[2:0], offset[2:0]};

   // NOTE: every signal written here gets its default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      strobe_d     = strobe_q;
      data_d       = data_q;
      resp_addr_ok = 1'b0;
      resp_data_ok = 1'b0;

      unique case (state_q)
         IDLE: begin
            resp_addr_ok = req_valid;
            if (req_valid) begin
               addr_d   = {req_addr[63:3], 3'b000};
               strobe_d = req_strobe;
               data_d   = req_data;
               cnt_d    = CNT_LOAD;
               state_d  = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_data_ok = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset silences the outputs in the very cycle it is asserted.
      if (reset) begin
         resp_addr_ok = 1'b0;
         resp_data_ok = 1'b0;
      end
   end

   // Read-before-write: the word is read combinationally during RESP and the store
   // lands at the edge that closes RESP, so a store returns the pre-write word.
   always_comb begin
      resp_data = '0;
      if (state_q == RESP && in_range && !reset) begin
         resp_data = mem[idx];
      end
   end

   assign wr_en = (state_q == RESP) && in_range && (strobe_q != 8'h00) && !reset;

   // NOTE: sequential state uses non-blocking assignments so every flop samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         strobe_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
      end
   end

   // NOTE: the array has no reset branch; clearing it would need a port per word and
   // the contents are defined only by what has been stored.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 8; b++) begin
            if (strobe_q[b]) begin
               mem[idx][8*b +: 8] <= data_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: a LATENCY=2 instance and a LATENCY=1 instance driven by
// directed vectors, hand-written reset sequences and random traffic against a word-level model.
module tb_dbus_sram_responder;

   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam int          DEPTH0 = 512;
   localparam int          DEPTH1 = 16;
   localparam int          LAT0   = 2;
   localparam logic [63:0] PRE    = 64'hA5A5_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid0, req_valid1;
   logic [63:0] req_addr;
   logic [2:0]  req_size;
   logic [7:0]  req_strobe;
   logic [63:0] req_data;
   logic        ao0, dok0, ao1, dok1;
   logic [63:0] rd0, rd1;

   logic        sel;
   logic        ao, dok;
   logic [63:0] rd;
   assign ao  = sel ? ao1  : ao0;
   assign dok = sel ? dok1 : dok0;
   assign rd  = sel ? rd1  : rd0;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem0 [longint];
   logic [63:0] mem1 [longint];

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  stb;
      logic [63:0] data;
      logic [63:0] exp;
      bit          hold;
      string       name;
   } vec_t;

   vec_t vecs[$];

   dbus_sram_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(LAT0), .BASE_ADDR(BASE)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_addr(req_addr),
      .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
      .resp_addr_ok(ao0), .resp_data_ok(dok0), .resp_data(rd0)
   );

   dbus_sram_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_addr(req_addr),
      .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
      .resp_addr_ok(ao1), .resp_data_ok(dok1), .resp_data(rd1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [63:0] addr, input logic [7:0] stb,
                               input logic [63:0] data, input logic [63:0] exp, input bit hold);
      vec_t v;
      v.name = name; v.addr = addr; v.stb = stb; v.data = data; v.exp = exp; v.hold = hold;
      return v;
   endfunction

   // Word index of a byte address, or -1 when it falls outside the scratch-pad.
   function automatic longint word_idx(input logic [63:0] a, input logic s);
      logic [63:0] w;
      longint      depth;
      w     = {a[63:3], 3'b000};
      depth = s ? DEPTH1 : DEPTH0;
      if (w < BASE) return -1;
      if ((w - BASE) / 8 >= 64'(depth)) return -1;
      return longint'((w - BASE) / 8);
   endfunction

   // Expected response (pre-write word) and memory update for one request.
   task automatic model_txn(input logic s, input logic [63:0] a, input logic [7:0] stb,
                            input logic [63:0] d, output bit known, output logic [63:0] exp);
      longint      idx;
      bit          have;
      logic [63:0] old, nw;
      idx   = word_idx(a, s);
      known = 1'b1;
      exp   = '0;
      if (idx < 0) return;
      have  = s ? mem1.exists(idx) : mem0.exists(idx);
      old   = '0;
      if (have) old = s ? mem1[idx] : mem0[idx];
      known = have;
      exp   = old;
      if (stb != 8'h00 && (have || stb == 8'hFF)) begin
         nw = old;
         for (int b = 0; b < 8; b++) begin
            if (stb[b]) nw[8*b +: 8] = d[8*b +: 8];
         end
         if (s) mem1[idx] = nw;
         else   mem0[idx] = nw;
      end
   endtask

   // One complete request with full timing checks; returns resp_data of the data_ok cycle.
   task automatic txn(input logic s, input logic [63:0] a, input logic [7:0] stb,
                      input logic [63:0] d, input bit hold, output logic [63:0] rdata);
      int lat;
      lat   = s ? 1 : LAT0;
      rdata = '0;
      @(negedge clk);
      sel        = s;
      req_addr   = a;
      req_strobe = stb;
      req_data   = d;
      req_size   = 3'd3;
      if (s) req_valid1 = 1'b1;
      else   req_valid0 = 1'b1;
      #1;
      check("accept addr_ok", {63'd0, ao}, 64'd1);
      check("accept data_ok", {63'd0, dok}, 64'd0);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (!hold) begin
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
            req_addr   = {$urandom, $urandom};
            req_strobe = 8'($urandom);
            req_data   = {$urandom, $urandom};
         end
         #1;
         check("busy addr_ok", {63'd0, ao}, 64'd0);
         if (k < lat) begin
            check("wait data_ok", {63'd0, dok}, 64'd0);
            check("wait resp_data", rd, 64'd0);
         end else begin
            check("resp data_ok", {63'd0, dok}, 64'd1);
            rdata = rd;
         end
      end
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
   endtask

   task automatic access(input logic s, input logic [63:0] a, input logic [7:0] stb,
                         input logic [63:0] d, input bit hold, input bit chk);
      bit          known;
      logic [63:0] exp, got;
      model_txn(s, a, stb, d, known, exp);
      txn(s, a, stb, d, hold, got);
      if (chk && known) check(s ? "lat1 random resp_data" : "random resp_data", got, exp);
   endtask

   function automatic logic [63:0] rand_addr(input int depth);
      logic [63:0] a;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 6)       a = BASE + 64'(8 * $urandom_range(0, 15));
      else if (r == 6) a = BASE + 64'(8 * (depth - 1));
      else if (r == 7) a = BASE - 64'(8 * $urandom_range(1, 4));
      else if (r == 8) a = BASE + 64'(8 * (depth + $urandom_range(0, 3)));
      else             a = {$urandom, $urandom};
      a[2:0] = 3'($urandom_range(0, 7));
      return a;
   endfunction

   initial begin
      logic [63:0] got;
      bit          known;
      logic [63:0] exp;

      sel = 1'b0; reset = 1'b1; req_valid0 = 1'b1; req_valid1 = 1'b1;
      req_addr = BASE; req_size = 3'd3; req_strobe = 8'hFF; req_data = '1;

      // Reset with a request present: nothing accepted, all outputs low.
      repeat (2) begin
         @(negedge clk); #1;
         check("reset addr_ok", {62'd0, ao0, ao1}, 64'd0);
         check("reset data_ok", {62'd0, dok0, dok1}, 64'd0);
         check("reset resp_data", rd0 | rd1, 64'd0);
      end
      @(negedge clk);
      reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;

      // Preload the words the tests touch with known values.
      for (int w = 0; w < 16; w++) access(1'b0, BASE + 64'(8 * w), 8'hFF, PRE | 64'(w), 1'b1, 1'b0);
      access(1'b0, BASE + 64'(8 * (DEPTH0 - 1)), 8'hFF, PRE | 64'(DEPTH0 - 1), 1'b1, 1'b0);
      for (int w = 0; w < DEPTH1; w++) access(1'b1, BASE + 64'(8 * w), 8'hFF, PRE | 64'(w), 1'b1, 1'b0);

      vecs.push_back(mk("store full prior", 64'h8000_0010, 8'hFF, 64'h1122334455667788, PRE | 64'd2, 1'b1));
      vecs.push_back(mk("load full",        64'h8000_0010, 8'h00, 64'h0, 64'h1122334455667788, 1'b1));
      vecs.push_back(mk("store part prior", 64'h8000_0010, 8'h0F, 64'hAAAABBBBCCCCDDDD, 64'h1122334455667788, 1'b1));
      vecs.push_back(mk("load part",        64'h8000_0010, 8'h00, 64'h0, 64'h11223344CCCCDDDD, 1'b1));
      vecs.push_back(mk("load low bits, valid dropped", 64'h8000_0015, 8'h00, 64'h0, 64'h11223344CCCCDDDD, 1'b0));
      vecs.push_back(mk("load below base",  64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1));
      vecs.push_back(mk("load past end",    64'h8000_1000, 8'h00, 64'h0, 64'h0, 1'b1));
      vecs.push_back(mk("store past end",   64'h8000_1000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1));
      vecs.push_back(mk("load word0",       64'h8000_0000, 8'h00, 64'h0, PRE, 1'b1));
      vecs.push_back(mk("store last prior", 64'h8000_0FF8, 8'hFF, 64'h0123456789ABCDEF, PRE | 64'h1FF, 1'b1));
      vecs.push_back(mk("load last",        64'h8000_0FF8, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b1));
      vecs.push_back(mk("store wrapped",    64'h0000_0000, 8'hFF, 64'h5555_5555_5555_5555, 64'h0, 1'b1));
      vecs.push_back(mk("store mixed prior", 64'h8000_0008, 8'h81, 64'h9900_0000_0000_0077, PRE | 64'd1, 1'b0));
      vecs.push_back(mk("load mixed",       64'h8000_0008, 8'h00, 64'h0, 64'h99A5_0000_0000_0077, 1'b1));

      foreach (vecs[i]) begin
         model_txn(1'b0, vecs[i].addr, vecs[i].stb, vecs[i].data, known, exp);
         txn(1'b0, vecs[i].addr, vecs[i].stb, vecs[i].data, vecs[i].hold, got);
         check(vecs[i].name, got, vecs[i].exp);
      end

      // req_valid held high: acceptances every LAT0+1 cycles, one-cycle data_ok.
      sel = 1'b0;
      for (int c = 0; c < 4 * (LAT0 + 1); c++) begin
         @(negedge clk);
         if (c == 0) begin
            req_valid0 = 1'b1; req_addr = 64'h8000_0010; req_strobe = 8'h00;
         end
         #1;
         check("held addr_ok", {63'd0, ao0}, {63'd0, c % (LAT0 + 1) == 0});
         check("held data_ok", {63'd0, dok0}, {63'd0, c % (LAT0 + 1) == LAT0});
         if (c % (LAT0 + 1) == LAT0) check("held resp_data", rd0, 64'h11223344CCCCDDDD);
      end
      req_valid0 = 1'b0;

      // Store to word 3 aborted by reset in WAIT; a load follows right after reset.
      @(negedge clk);
      req_valid0 = 1'b1; req_addr = 64'h8000_0018; req_strobe = 8'hFF; req_data = 64'hDEAD_BEEF_DEAD_BEEF;
      #1; check("abort accept", {63'd0, ao0}, 64'd1);
      @(negedge clk); reset = 1'b1;
      #1; check("reset+valid addr_ok", {63'd0, ao0}, 64'd0);
      check("reset wait data_ok", {63'd0, dok0}, 64'd0);
      @(negedge clk); reset = 1'b0; req_strobe = 8'h00;
      #1; check("no data_ok after abort", {63'd0, dok0}, 64'd0);
      check("accept after reset", {63'd0, ao0}, 64'd1);
      @(negedge clk); req_valid0 = 1'b0;
      #1; check("post-reset wait data_ok", {63'd0, dok0}, 64'd0);
      @(negedge clk);
      #1; check("post-reset data_ok", {63'd0, dok0}, 64'd1);
      check("aborted store not written", rd0, PRE | 64'd3);
      req_valid0 = 1'b0;

      // Store to word 4 aborted by reset during RESP.
      @(negedge clk);
      req_valid0 = 1'b1; req_addr = 64'h8000_0020; req_strobe = 8'hFF; req_data = 64'h0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      #1; check("reset resp data_ok", {63'd0, dok0}, 64'd0);
      check("reset resp resp_data", rd0, 64'd0);
      @(negedge clk); reset = 1'b0; req_valid0 = 1'b0;
      txn(1'b0, 64'h8000_0020, 8'h00, 64'h0, 1'b1, got);
      check("resp-aborted store not written", got, PRE | 64'd4);

      // LATENCY=1 instance.
      txn(1'b1, BASE, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b1, got);
      check("lat1 store prior", got, PRE);
      txn(1'b1, BASE, 8'h00, 64'h0, 1'b1, got);
      check("lat1 load", got, 64'hCAFE_F00D_1234_5678);
      model_txn(1'b1, BASE, 8'hFF, 64'hCAFE_F00D_1234_5678, known, exp);

      // Random traffic against the model.
      for (int n = 0; n < 200; n++) begin
         access(1'b0, rand_addr(DEPTH0), ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 3) != 0, 1'b1);
      end
      for (int n = 0; n < 80; n++) begin
         access(1'b1, rand_addr(DEPTH1), ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 3) != 0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
